// File: rtl/tip_arty_reset_pkg.sv
// Shared types and constants for the Arty platform reset sequencer.
// Holds the sequencer state encoding, the reset-cause codes and a counter-width helper.
// No logic; imported by the sequencer and its debounce sub-module.
package tip_arty_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        PERI_REL  = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [2:0] CAUSE_POR    = 3'd0;
    localparam logic [2:0] CAUSE_LOCK   = 3'd1;
    localparam logic [2:0] CAUSE_BUTTON = 3'd2;
    localparam logic [2:0] CAUSE_SW     = 3'd3;
    localparam logic [2:0] CAUSE_WDT    = 3'd4;

    // Counter width for a count of 'cycles' states, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/tip_arty_reset_debounce.sv
// Purpose: 2-flop synchronizer followed by a stable-count filter for a bouncy async level.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples before dout follows din.
// Backpressure: none; free-running level filter.
module tip_arty_reset_debounce
    import tip_arty_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_system,
    input  logic rst_system,
    input  logic din,
    output logic dout
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous input into the clk_system domain.
    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the filtered output
    // for DEBOUNCE_CYCLES consecutive samples; returning to the old level restarts.
    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_db  <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign dout = r_db;

endmodule

// File: rtl/tip_arty_reset_sequencer.sv
// Purpose: ordered peripheral/core reset release after PLL lock, re-entry on lock loss,
//          button, software request (and watchdog when TIP_ARTY_RESET_SEQ_WDT_EN is defined).
// Latency: lock rise -> STRETCH in 3 edges; rst_peri +STRETCH_CYCLES; rst_core/ready +PERI_DELAY.
// Backpressure: none; sw_rst_req outside RUN is dropped, not queued.
module tip_arty_reset_sequencer
    import tip_arty_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STRETCH_CYCLES  = 256,
    parameter int PERI_DELAY      = 16,
    parameter int WDT_CYCLES      = 2**20
) (
    input  logic       clk_system,
    input  logic       rst_system,
    input  logic       pll_locked,
    input  logic       button_rst,
    input  logic       sw_rst_req,
    input  logic       wdt_kick,
    output logic       rst_peri,
    output logic       rst_core,
    output logic       ready,
    output logic [2:0] rst_cause
);

    localparam int            SW           = cnt_width(STRETCH_CYCLES);
    localparam int            PW           = cnt_width(PERI_DELAY);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
    localparam logic [PW-1:0] PERI_LAST    = PW'(PERI_DELAY - 1);

    logic          r_lock_s1;
    logic          r_lock_s2;
    logic          w_btn_db;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_stretch_cnt;
    logic [SW-1:0] w_stretch_cnt_nxt;
    logic [PW-1:0] r_peri_cnt;
    logic [PW-1:0] w_peri_cnt_nxt;
    logic [2:0]    r_cause;
    logic [2:0]    w_cause_nxt;
    logic          r_rst_peri;
    logic          r_rst_core;
    logic          r_ready;

    tip_arty_reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_system (clk_system),
        .rst_system (rst_system),
        .din        (button_rst),
        .dout       (w_btn_db)
    );

    // PLL lock only needs synchronizing; it does not bounce.
    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

`ifdef TIP_ARTY_RESET_SEQ_WDT_EN
    localparam int            WW       = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] r_wdt_cnt;
    logic          w_wdt_fire;

    assign w_wdt_fire = (r_state == RUN) && (r_wdt_cnt == WDT_LAST);

    // Watchdog counts only while running; a kick or leaving RUN clears it.
    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            r_wdt_cnt <= '0;
        end else if (r_state != RUN || wdt_kick || w_wdt_fire) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog the kick input and timeout are deliberately ignored.
    logic w_unused_wdt;
    assign w_unused_wdt = wdt_kick & (WDT_CYCLES > 0);
`endif

    // State, counters, cause and the reset outputs all update on one edge.
    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            r_state       <= WAIT_LOCK;
            r_stretch_cnt <= '0;
            r_peri_cnt    <= '0;
            r_cause       <= CAUSE_POR;
            r_rst_peri    <= 1'b1;
            r_rst_core    <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stretch_cnt <= w_stretch_cnt_nxt;
            r_peri_cnt    <= w_peri_cnt_nxt;
            r_cause       <= w_cause_nxt;
            r_rst_peri    <= (w_state_nxt == WAIT_LOCK) || (w_state_nxt == STRETCH);
            r_rst_core    <= (w_state_nxt != RUN);
            r_ready       <= (w_state_nxt == RUN);
        end
    end

    // Next-state logic; counters idle at zero outside their own state.
    always_comb begin
        w_state_nxt       = r_state;
        w_stretch_cnt_nxt = '0;
        w_peri_cnt_nxt    = '0;
        w_cause_nxt       = r_cause;
        case (r_state)
            WAIT_LOCK: begin
                if (r_lock_s2) begin
                    w_state_nxt = STRETCH;
                end
            end
            STRETCH: begin
                if (!r_lock_s2) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_btn_db) begin
                    w_stretch_cnt_nxt = '0;
                end else if (r_stretch_cnt == STRETCH_LAST) begin
                    w_state_nxt = PERI_REL;
                end else begin
                    w_stretch_cnt_nxt = r_stretch_cnt + 1'b1;
                end
            end
            PERI_REL: begin
                if (!r_lock_s2) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_peri_cnt == PERI_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_peri_cnt_nxt = r_peri_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!r_lock_s2) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cause_nxt = CAUSE_LOCK;
                end else if (w_btn_db) begin
                    w_state_nxt = STRETCH;
                    w_cause_nxt = CAUSE_BUTTON;
                end else if (sw_rst_req) begin
                    w_state_nxt = STRETCH;
                    w_cause_nxt = CAUSE_SW;
`ifdef TIP_ARTY_RESET_SEQ_WDT_EN
                end else if (w_wdt_fire) begin
                    w_state_nxt = STRETCH;
                    w_cause_nxt = CAUSE_WDT;
`endif
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    assign rst_peri  = r_rst_peri;
    assign rst_core  = r_rst_core;
    assign ready     = r_ready;
    assign rst_cause = r_cause;

endmodule

// File: tb/tb_tip_arty_reset_sequencer.sv
// Directed bench for the reset sequencer with STRETCH=8, PERI=4, DEBOUNCE=5, WDT=32.
// Cycle numbers are counts of rising edges; inputs change and outputs are read 1 unit after an edge.
// Expected values are hand-computed edge numbers for each scenario.
module tb_tip_arty_reset_sequencer;

    logic       clk_system = 1'b0;
    logic       rst_system = 1'b1;
    logic       pll_locked = 1'b0;
    logic       button_rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_kick   = 1'b0;
    logic       rst_peri;
    logic       rst_core;
    logic       ready;
    logic [2:0] rst_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int now     = 0;
    bit kick_en = 1'b1;

    tip_arty_reset_sequencer #(
        .DEBOUNCE_CYCLES (5),
        .STRETCH_CYCLES  (8),
        .PERI_DELAY      (4),
        .WDT_CYCLES      (32)
    ) dut (
        .clk_system (clk_system),
        .rst_system (rst_system),
        .pll_locked (pll_locked),
        .button_rst (button_rst),
        .sw_rst_req (sw_rst_req),
        .wdt_kick   (wdt_kick),
        .rst_peri   (rst_peri),
        .rst_core   (rst_core),
        .ready      (ready),
        .rst_cause  (rst_cause)
    );

    always #5 clk_system = ~clk_system;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, now, obs, exp);
        end
    endtask

    // Advance to 1 unit after rising edge number k.
    task automatic goto(input int k);
        while (now < k) begin
            @(posedge clk_system);
            now++;
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic c, input logic r);
        chk({tag, ".rst_peri"}, {7'd0, rst_peri}, {7'd0, p});
        chk({tag, ".rst_core"}, {7'd0, rst_core}, {7'd0, c});
        chk({tag, ".ready"},    {7'd0, ready},    {7'd0, r});
    endtask

    // Periodic watchdog kick, one cycle wide, roughly every 21 cycles while enabled.
    initial begin
        forever begin
            repeat (20) @(posedge clk_system);
            #1;
            if (kick_en) wdt_kick = 1'b1;
            @(posedge clk_system);
            #1;
            wdt_kick = 1'b0;
        end
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        goto(3);
        chk_out("reset", 1'b1, 1'b1, 1'b0);
        chk("reset.cause", {5'd0, rst_cause}, 8'd0);
        rst_system = 1'b0;

        // 1: power-up, lock rises at cycle 10
        goto(10);
        pll_locked = 1'b1;
        goto(20); chk_out("pwr20", 1'b1, 1'b1, 1'b0);
        goto(21); chk_out("pwr21", 1'b0, 1'b1, 1'b0);
        goto(24); chk_out("pwr24", 1'b0, 1'b1, 1'b0);
        goto(25); chk_out("pwr25", 1'b0, 1'b0, 1'b1);
        chk("pwr.cause", {5'd0, rst_cause}, 8'd0);

        // 2: lock loss for 3 cycles in RUN, then relock
        goto(30); pll_locked = 1'b0;
        goto(32); chk_out("lol32", 1'b0, 1'b0, 1'b1);
        goto(33); chk_out("lol33", 1'b1, 1'b1, 1'b0);
        chk("lol.cause", {5'd0, rst_cause}, 8'd1);
        pll_locked = 1'b1;
        goto(43); chk_out("relock43", 1'b1, 1'b1, 1'b0);
        goto(44); chk_out("relock44", 1'b0, 1'b1, 1'b0);
        goto(47); chk_out("relock47", 1'b0, 1'b1, 1'b0);
        goto(48); chk_out("relock48", 1'b0, 1'b0, 1'b1);
        chk("relock.cause", {5'd0, rst_cause}, 8'd1);

        // 3: button glitches are filtered, a long press resets
        goto(60); button_rst = 1'b1;
        goto(63); button_rst = 1'b0;
        goto(66); button_rst = 1'b1;
        goto(69); button_rst = 1'b0;
        goto(75); chk_out("glitch75", 1'b0, 1'b0, 1'b1);
        goto(80); button_rst = 1'b1;
        goto(87); chk_out("btn87", 1'b0, 1'b0, 1'b1);
        goto(88); chk_out("btn88", 1'b1, 1'b1, 1'b0);
        chk("btn.cause", {5'd0, rst_cause}, 8'd2);
        goto(100); button_rst = 1'b0;
        goto(114); chk_out("btnrel114", 1'b1, 1'b1, 1'b0);
        goto(115); chk_out("btnrel115", 1'b0, 1'b1, 1'b0);
        goto(118); chk_out("btnrel118", 1'b0, 1'b1, 1'b0);
        goto(119); chk_out("btnrel119", 1'b0, 1'b0, 1'b1);

        // 4: software request in RUN, then one ignored during PERI_REL
        goto(125); sw_rst_req = 1'b1;
        chk_out("sw125", 1'b0, 1'b0, 1'b1);
        goto(126); sw_rst_req = 1'b0;
        chk_out("sw126", 1'b1, 1'b1, 1'b0);
        chk("sw.cause", {5'd0, rst_cause}, 8'd3);
        goto(134); chk_out("sw134", 1'b0, 1'b1, 1'b0);
        goto(135); sw_rst_req = 1'b1;
        goto(136); sw_rst_req = 1'b0;
        goto(137); chk_out("swperi137", 1'b0, 1'b1, 1'b0);
        goto(138); chk_out("swperi138", 1'b0, 1'b0, 1'b1);
        chk("swperi.cause", {5'd0, rst_cause}, 8'd3);

        // 5: lock loss and software request on the same edge; lock loss wins
        goto(145); pll_locked = 1'b0;
        goto(147); sw_rst_req = 1'b1;
        goto(148); sw_rst_req = 1'b0;
        chk_out("simul148", 1'b1, 1'b1, 1'b0);
        chk("simul.cause", {5'd0, rst_cause}, 8'd1);
        goto(150); pll_locked = 1'b1;
        // global reset mid-STRETCH (STRETCH entered at 153)
        goto(156); rst_system = 1'b1;
        goto(157); rst_system = 1'b0;
        chk_out("rstmid157", 1'b1, 1'b1, 1'b0);
        chk("rstmid.cause", {5'd0, rst_cause}, 8'd0);
        goto(161); chk_out("rstmid161", 1'b1, 1'b1, 1'b0);
        goto(168); chk_out("rstmid168", 1'b0, 1'b1, 1'b0);
        goto(172); chk_out("rstmid172", 1'b0, 1'b0, 1'b1);

        // 6: watchdog; periodic kicks keep RUN, then stop kicking after a fresh RUN entry
        goto(250); chk_out("kick250", 1'b0, 1'b0, 1'b1);
        kick_en = 1'b0;
        sw_rst_req = 1'b1;
        goto(251); sw_rst_req = 1'b0;
        goto(263); chk_out("wdt263", 1'b0, 1'b0, 1'b1);
        goto(294); chk_out("wdt294", 1'b0, 1'b0, 1'b1);
        goto(295);
`ifdef TIP_ARTY_RESET_SEQ_WDT_EN
        chk_out("wdt295", 1'b1, 1'b1, 1'b0);
        chk("wdt.cause", {5'd0, rst_cause}, 8'd4);
`else
        chk_out("wdt295", 1'b0, 1'b0, 1'b1);
        chk("wdt.cause", {5'd0, rst_cause}, 8'd3);
`endif
        goto(330);
`ifndef TIP_ARTY_RESET_SEQ_WDT_EN
        chk_out("nowdt330", 1'b0, 1'b0, 1'b1);
`else
        chk_out("wdtrun330", 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
